// File: rtl/pipe_ctrl_hazard.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_hazard
//
// Pipelined control path for the MIPS-style core. Decoded control bits from
// ID are carried through the ID/EX, EX/MEM and MEM/WB control registers, and
// the hazard unit produces forwarding selects plus stall/flush controls for
// the datapath. A multi-cycle mul/div holds EX for MULDIV_CYCLES cycles via
// an occupancy counter.
//
// Parameters:
//   REG_ADDR_W    register-address width
//   ALUCTRL_W     ALU control width
//   MULDIV_CYCLES cycles a mul/div occupies EX (must be >= 2)
//   CNT_W         occupancy counter width (2**CNT_W > MULDIV_CYCLES)
//
// Ports:
//   CLK, RST_N                  clock, synchronous active-low reset
//   *D controls, ALUControlD    decoded controls from the control unit
//   RsD/RtD/RsE/RtE/WriteReg*   register addresses from the datapath
//   ALUSrcE, RegDstE, MulDivE, ALUControlE   EX-stage controls
//   MemWriteM, RegWriteW, MemToRegW          later-stage controls
//   StallF/D/E, FlushD/E/M      pipeline stall and flush controls
//   ForwardAD/BD                ID branch-compare forwarding
//   ForwardAE/BE                EX operand forwarding (10=M, 01=W, 00=RF)
//   MulDivBusy                  occupancy counter is non-zero
//
// Optional feature (macro PIPE_BRANCH_FLUSH_EN):
//   Defined   - adds PCSrcD/JumpD inputs; FlushD squashes the wrong-path
//               IF/ID instruction on a taken branch or jump (no delay slot).
//   Undefined - FlushD is tied low and delay-slot semantics apply.
// ---------------------------------------------------------------------------
module pipe_ctrl_hazard #(
    parameter int REG_ADDR_W    = 5,
    parameter int ALUCTRL_W     = 4,
    parameter int MULDIV_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  RegWriteD,
    input  logic                  MemToRegD,
    input  logic                  MemWriteD,
    input  logic                  ALUSrcD,
    input  logic                  RegDstD,
    input  logic                  BranchD,
    input  logic                  MulDivD,
    input  logic [ALUCTRL_W-1:0]  ALUControlD,
`ifdef PIPE_BRANCH_FLUSH_EN
    input  logic                  PCSrcD,
    input  logic                  JumpD,
`endif
    input  logic [REG_ADDR_W-1:0] RsD,
    input  logic [REG_ADDR_W-1:0] RtD,
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RtE,
    input  logic [REG_ADDR_W-1:0] WriteRegE,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegW,
    output logic                  ALUSrcE,
    output logic                  RegDstE,
    output logic                  MulDivE,
    output logic [ALUCTRL_W-1:0]  ALUControlE,
    output logic                  MemWriteM,
    output logic                  RegWriteW,
    output logic                  MemToRegW,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic                  FlushD,
    output logic                  ForwardAD,
    output logic                  ForwardBD,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MulDivBusy
);

    // Stage-internal control bits that are not exported as ports.
    logic             regWriteE;
    logic             memToRegE;
    logic             memWriteE;
    logic             regWriteM;
    logic             memToRegM;
    logic [CNT_W-1:0] cnt;
    logic             lwStall;
    logic             brStall;
    logic             mdStall;

    // A producer matches a consumer only when it writes, targets a non-zero
    // register, and the addresses agree; $0 is hardwired and never hazards.
    function automatic logic regHit(input logic                  writes,
                                    input logic [REG_ADDR_W-1:0] dst,
                                    input logic [REG_ADDR_W-1:0] src);
        return writes && (dst != '0) && (dst == src);
    endfunction

    // Forwarding selects. EX operands prefer the younger MEM result over WB;
    // the ID branch compare can only use the MEM result.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (regHit(regWriteM, WriteRegM, RsE))
            ForwardAE = 2'b10;
        else if (regHit(RegWriteW, WriteRegW, RsE))
            ForwardAE = 2'b01;
        if (regHit(regWriteM, WriteRegM, RtE))
            ForwardBE = 2'b10;
        else if (regHit(RegWriteW, WriteRegW, RtE))
            ForwardBE = 2'b01;
        ForwardAD = regHit(regWriteM, WriteRegM, RsD);
        ForwardBD = regHit(regWriteM, WriteRegM, RtD);
    end

    // Hazard detection. A branch resolved in ID must wait for an ALU result
    // still in EX or a load result still in MEM. The mul/div stall covers the
    // first cycle (counter not yet loaded) and every cycle the counter is
    // above one, which gives MULDIV_CYCLES-1 stall cycles in total.
    always_comb begin
        lwStall = memToRegE &&
                  (regHit(regWriteE, WriteRegE, RsD) || regHit(regWriteE, WriteRegE, RtD));
        brStall = BranchD &&
                  (regHit(regWriteE, WriteRegE, RsD) || regHit(regWriteE, WriteRegE, RtD) ||
                   regHit(memToRegM, WriteRegM, RsD) || regHit(memToRegM, WriteRegM, RtD));
        mdStall = (MulDivE && (cnt == '0)) || (cnt > CNT_W'(1));
    end

    // While mul/div holds EX the ID/EX register must not be flushed, so the
    // load-use/branch bubble is only inserted when EX is free to advance.
    assign StallF     = lwStall || brStall || mdStall;
    assign StallD     = StallF;
    assign StallE     = mdStall;
    assign FlushE     = (lwStall || brStall) && !mdStall;
    assign FlushM     = mdStall;
    assign MulDivBusy = (cnt != '0);

`ifdef PIPE_BRANCH_FLUSH_EN
    assign FlushD = (PCSrcD || JumpD) && !StallD;
`else
    assign FlushD = 1'b0;
`endif

    // Mul/div occupancy counter. Reset abandons any operation in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N)
            cnt <= '0;
        else if (MulDivE && (cnt == '0))
            cnt <= CNT_W'(MULDIV_CYCLES - 1);
        else if (cnt > CNT_W'(1))
            cnt <= cnt - CNT_W'(1);
        else if (cnt == CNT_W'(1))
            cnt <= '0;
    end

    // ID/EX control register: hold under a mul/div stall, bubble on flush,
    // otherwise capture the decoded controls.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            regWriteE   <= 1'b0;
            memToRegE   <= 1'b0;
            memWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            MulDivE     <= 1'b0;
            ALUControlE <= '0;
        end else if (StallE) begin
            regWriteE   <= regWriteE;
            memToRegE   <= memToRegE;
            memWriteE   <= memWriteE;
            ALUSrcE     <= ALUSrcE;
            RegDstE     <= RegDstE;
            MulDivE     <= MulDivE;
            ALUControlE <= ALUControlE;
        end else if (FlushE) begin
            regWriteE   <= 1'b0;
            memToRegE   <= 1'b0;
            memWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            MulDivE     <= 1'b0;
            ALUControlE <= '0;
        end else begin
            regWriteE   <= RegWriteD;
            memToRegE   <= MemToRegD;
            memWriteE   <= MemWriteD;
            ALUSrcE     <= ALUSrcD;
            RegDstE     <= RegDstD;
            MulDivE     <= MulDivD;
            ALUControlE <= ALUControlD;
        end
    end

    // EX/MEM control register: a held EX stage feeds bubbles into MEM.
    always_ff @(posedge CLK) begin
        if (!RST_N || FlushM) begin
            regWriteM <= 1'b0;
            memToRegM <= 1'b0;
            MemWriteM <= 1'b0;
        end else begin
            regWriteM <= regWriteE;
            memToRegM <= memToRegE;
            MemWriteM <= memWriteE;
        end
    end

    // MEM/WB control register: never stalls.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
        end else begin
            RegWriteW <= regWriteM;
            MemToRegW <= memToRegM;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_hazard
//
// Directed checks of reset, forwarding priority, load-use, branch and mul/div
// stalls and FlushD, followed by a randomized phase compared every cycle
// against an instruction-level model of the control pipeline.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_hazard;

    localparam int RAW = 5;
    localparam int ACW = 4;
    localparam int MDC = 8;
    localparam int CW  = 4;
`ifdef PIPE_BRANCH_FLUSH_EN
    localparam logic BFE = 1'b1;
`else
    localparam logic BFE = 1'b0;
`endif

    logic           CLK, RST_N;
    logic           RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, MulDivD;
    logic [ACW-1:0] ALUControlD;
`ifdef PIPE_BRANCH_FLUSH_EN
    logic           PCSrcD, JumpD;
`endif
    logic [RAW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic           ALUSrcE, RegDstE, MulDivE;
    logic [ACW-1:0] ALUControlE;
    logic           MemWriteM, RegWriteW, MemToRegW;
    logic           StallF, StallD, StallE, FlushE, FlushM, FlushD;
    logic           ForwardAD, ForwardBD;
    logic [1:0]     ForwardAE, ForwardBE;
    logic           MulDivBusy;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: one record per pipeline stage plus the number of
    // cycles the EX instruction has already spent in EX.
    logic           eRW, eM2R, eMW, eAS, eRD, eMD;
    logic [ACW-1:0] eALU;
    logic           mRW, mM2R, mMW, wRW, wM2R;
    int             exAge;
    logic           expHoldE, expFlushE;

    pipe_ctrl_hazard #(
        .REG_ADDR_W(RAW), .ALUCTRL_W(ACW), .MULDIV_CYCLES(MDC), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .BranchD(BranchD), .MulDivD(MulDivD),
        .ALUControlD(ALUControlD),
`ifdef PIPE_BRANCH_FLUSH_EN
        .PCSrcD(PCSrcD), .JumpD(JumpD),
`endif
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .MulDivE(MulDivE), .ALUControlE(ALUControlE),
        .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushE(FlushE), .FlushM(FlushM), .FlushD(FlushD),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MulDivBusy(MulDivBusy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are read there too.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic setD(input logic rw, m2r, mw, as, rd, br, md, input logic [ACW-1:0] alu);
        RegWriteD = rw; MemToRegD = m2r; MemWriteD = mw; ALUSrcD = as;
        RegDstD = rd; BranchD = br; MulDivD = md; ALUControlD = alu;
    endtask

    task automatic clearAddr();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
`ifdef PIPE_BRANCH_FLUSH_EN
        PCSrcD = 1'b0; JumpD = 1'b0;
`endif
    endtask

    task automatic applyStimulus();
        RST_N       = ($urandom_range(0, 49) != 0);
        RegWriteD   = 1'($urandom_range(0, 1));
        MemToRegD   = ($urandom_range(0, 2) == 0);
        MemWriteD   = 1'($urandom_range(0, 1));
        ALUSrcD     = 1'($urandom_range(0, 1));
        RegDstD     = 1'($urandom_range(0, 1));
        BranchD     = ($urandom_range(0, 3) == 0);
        MulDivD     = ($urandom_range(0, 9) == 0);
        ALUControlD = ACW'($urandom);
        RsD = RAW'($urandom_range(0, 3));  RtD = RAW'($urandom_range(0, 3));
        RsE = RAW'($urandom_range(0, 3));  RtE = RAW'($urandom_range(0, 3));
        WriteRegE = RAW'($urandom_range(0, 3));
        WriteRegM = RAW'($urandom_range(0, 3));
        WriteRegW = RAW'($urandom_range(0, 3));
`ifdef PIPE_BRANCH_FLUSH_EN
        PCSrcD = ($urandom_range(0, 3) == 0);
        JumpD  = ($urandom_range(0, 5) == 0);
`endif
    endtask

    function automatic logic dep(input logic writes, input logic [RAW-1:0] dst, input logic [RAW-1:0] src);
        return writes && (dst != 0) && (dst == src);
    endfunction

    // Expected outputs from the model state and current inputs.
    task automatic modelCheck();
        logic [1:0] fAE, fBE;
        logic       lw, br, md, stall, flE, flD, busy;
        fAE = dep(mRW, WriteRegM, RsE) ? 2'd2 : (dep(wRW, WriteRegW, RsE) ? 2'd1 : 2'd0);
        fBE = dep(mRW, WriteRegM, RtE) ? 2'd2 : (dep(wRW, WriteRegW, RtE) ? 2'd1 : 2'd0);
        lw  = eM2R && (dep(eRW, WriteRegE, RsD) || dep(eRW, WriteRegE, RtD));
        br  = BranchD && (dep(eRW, WriteRegE, RsD) || dep(eRW, WriteRegE, RtD) ||
                          dep(mM2R, WriteRegM, RsD) || dep(mM2R, WriteRegM, RtD));
        md    = eMD && (exAge < MDC - 1);
        busy  = eMD && (exAge >= 1);
        stall = lw || br || md;
        flE   = (lw || br) && !md;
`ifdef PIPE_BRANCH_FLUSH_EN
        flD = (PCSrcD || JumpD) && !stall;
`else
        flD = 1'b0;
`endif
        expHoldE  = md;
        expFlushE = flE;
        checkOutput("rand_fwd", 16'({ForwardAE, ForwardBE, ForwardAD, ForwardBD}),
                    16'({fAE, fBE, dep(mRW, WriteRegM, RsD), dep(mRW, WriteRegM, RtD)}));
        checkOutput("rand_stall", 16'({StallF, StallD, StallE, FlushE, FlushM, FlushD, MulDivBusy}),
                    16'({stall, stall, md, flE, md, flD, busy}));
        checkOutput("rand_pipe", 16'({ALUSrcE, RegDstE, MulDivE, ALUControlE, MemWriteM, RegWriteW, MemToRegW}),
                    16'({eAS, eRD, eMD, eALU, mMW, wRW, wM2R}));
    endtask

    task automatic modelReset();
        {eRW, eM2R, eMW, eAS, eRD, eMD} = '0;
        eALU = '0;
        {mRW, mM2R, mMW, wRW, wM2R} = '0;
        exAge = 0;
    endtask

    // Advance every instruction one stage, honouring the hold/flush decided
    // for this cycle.
    task automatic modelUpdate();
        if (!RST_N) begin
            modelReset();
        end else begin
            wRW = mRW; wM2R = mM2R;
            if (expHoldE) {mRW, mM2R, mMW} = '0;
            else          {mRW, mM2R, mMW} = {eRW, eM2R, eMW};
            if (expHoldE) begin
                exAge++;
            end else if (expFlushE) begin
                {eRW, eM2R, eMW, eAS, eRD, eMD} = '0;
                eALU = '0;
                exAge = 0;
            end else begin
                {eRW, eM2R, eMW, eAS, eRD, eMD} =
                    {RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, MulDivD};
                eALU = ALUControlD;
                exAge = 0;
            end
        end
    endtask

    initial begin
        int stallCnt, flushMCnt, busyCnt, stallFCnt;

        // Reset with every decoded control asserted.
        RST_N = 1'b0;
        clearAddr();
        setD(1, 1, 1, 1, 1, 1, 1, 4'hF);
        tick();
        tick();
        #1;
        checkOutput("rst_alu", 16'(ALUControlE), 16'h0);
        checkOutput("rst_ectl", 16'({ALUSrcE, RegDstE, MulDivE}), 16'h0);
        checkOutput("rst_mw", 16'({MemWriteM, RegWriteW, MemToRegW}), 16'h0);
        checkOutput("rst_busy", 16'(MulDivBusy), 16'h0);
        checkOutput("rst_stall", 16'({StallF, StallD, StallE, FlushE, FlushM, FlushD}), 16'h0);
        setD(0, 0, 0, 0, 0, 0, 0, 4'h0);
        RST_N = 1'b1;
        tick();

        // Latency: A (rw, mw, alusrc, alu 3) then B (rw, alu 5) then idle.
        setD(1, 0, 1, 1, 0, 0, 0, 4'h3);
        tick();
        #1;
        checkOutput("lat_e1", 16'({ALUSrcE, ALUControlE, MemWriteM}), 16'({1'b1, 4'h3, 1'b0}));
        setD(1, 0, 0, 0, 0, 0, 0, 4'h5);
        tick();
        #1;
        checkOutput("lat_e2", 16'({ALUSrcE, ALUControlE, MemWriteM, RegWriteW}), 16'({1'b0, 4'h5, 1'b1, 1'b0}));
        setD(0, 0, 0, 0, 0, 0, 0, 4'h0);
        tick();
        #1;
        checkOutput("lat_w", 16'({MemWriteM, RegWriteW}), 16'b01);

        // Forwarding priority with writers in both MEM and WB.
        WriteRegM = 5; WriteRegW = 5; RsE = 5; RtE = 5; RsD = 5;
        #1;
        checkOutput("fwd_mem", 16'({ForwardAE, ForwardBE, ForwardAD}), 16'b10_10_1);
        WriteRegM = 6;
        #1;
        checkOutput("fwd_wb", 16'({ForwardAE, ForwardBE, ForwardAD}), 16'b01_01_0);
        RsE = 0; RtE = 0; WriteRegM = 0; WriteRegW = 0; RsD = 0;
        #1;
        checkOutput("fwd_r0", 16'({ForwardAE, ForwardBE, ForwardAD}), 16'b00_00_0);

        // Load-use: lw $8 in EX, consumer of $8 in ID.
        clearAddr();
        setD(1, 1, 0, 1, 0, 0, 0, 4'h1);
        tick();
        setD(1, 0, 0, 0, 0, 0, 0, 4'h2);
        RsD = 8; WriteRegE = 8;
        #1;
        checkOutput("lu_stall", 16'({StallF, StallD, StallE, FlushE, FlushM}), 16'b11010);
        tick();
        WriteRegE = 0; WriteRegM = 8; RsE = 8;
        #1;
        checkOutput("lu_free", 16'({StallF, StallD, StallE, FlushE, FlushM}), 16'b00000);
        checkOutput("lu_bubble", 16'({ALUSrcE, ALUControlE}), 16'h0);
        checkOutput("lu_fwd", 16'({ForwardAE, ForwardAD}), 16'b10_1);
        tick();
        WriteRegM = 0; WriteRegW = 8;
        #1;
        checkOutput("lu_use", 16'({ALUControlE, RegWriteW, MemToRegW, ForwardAE}), 16'({4'h2, 2'b11, 2'b01}));
        setD(0, 0, 0, 0, 0, 0, 0, 4'h0);
        clearAddr();
        repeat (3) tick();

        // Branch depending on an ALU result in EX.
        setD(1, 0, 0, 0, 0, 0, 0, 4'h2);
        tick();
        setD(0, 0, 0, 0, 0, 1, 0, 4'h0);
        RsD = 1; RtD = 3; WriteRegE = 3;
        #1;
        checkOutput("br_stall", 16'({StallF, StallD, StallE, FlushE, FlushM, FlushD}), 16'b110100);
        tick();
        WriteRegE = 0; WriteRegM = 3;
        #1;
        checkOutput("br_free", 16'({StallF, StallD, FlushE}), 16'b000);
        checkOutput("br_fwd", 16'({ForwardAD, ForwardBD}), 16'b01);
        setD(0, 0, 0, 0, 0, 0, 0, 4'h0);
        clearAddr();
        repeat (3) tick();

        // Single mul/div followed by an ordinary instruction waiting in ID.
        setD(1, 0, 0, 0, 0, 0, 1, 4'h9);
        tick();
        setD(0, 0, 0, 0, 0, 0, 0, 4'h1);
        stallCnt = 0; flushMCnt = 0; busyCnt = 0; stallFCnt = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (StallE)     stallCnt++;
            if (FlushM)     flushMCnt++;
            if (MulDivBusy) busyCnt++;
            if (StallF)     stallFCnt++;
            if (i == 3) checkOutput("md_hold", 16'({MulDivE, ALUControlE}), 16'({1'b1, 4'h9}));
            if (i == 8) checkOutput("md_next", 16'({MulDivE, ALUControlE}), 16'({1'b0, 4'h1}));
            if (i == 9) checkOutput("md_wb", 16'(RegWriteW), 16'h1);
            tick();
        end
        checkOutput("md_stallE_cnt", 16'(stallCnt), 16'(MDC - 1));
        checkOutput("md_flushM_cnt", 16'(flushMCnt), 16'(MDC - 1));
        checkOutput("md_busy_cnt", 16'(busyCnt), 16'(MDC - 1));
        checkOutput("md_stallF_cnt", 16'(stallFCnt), 16'(MDC - 1));
        setD(0, 0, 0, 0, 0, 0, 0, 4'h0);
        repeat (3) tick();

        // Back-to-back mul/div: the second is already waiting in ID.
        setD(0, 0, 0, 0, 0, 0, 1, 4'h9);
        tick();
        stallCnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (StallE) stallCnt++;
            if (i == 8) setD(0, 0, 0, 0, 0, 0, 0, 4'h0);
            tick();
        end
        checkOutput("md_b2b_cnt", 16'(stallCnt), 16'(2 * (MDC - 1)));

        // Load-use hazard while EX is held by a mul/div: no EX flush.
        setD(1, 1, 0, 0, 0, 0, 1, 4'h9);
        tick();
        setD(0, 0, 0, 0, 0, 0, 0, 4'h0);
        RsD = 8; WriteRegE = 8;
        #1;
        checkOutput("md_lu0", 16'({StallF, StallE, FlushE, FlushM}), 16'b1101);
        tick();
        #1;
        checkOutput("md_lu1", 16'({StallF, StallE, FlushE, FlushM}), 16'b1101);
        clearAddr();
        repeat (10) tick();

        // FlushD: suppressed under a branch stall, raised on redirect otherwise.
        setD(1, 0, 0, 0, 0, 0, 0, 4'h2);
        tick();
        setD(0, 0, 0, 0, 0, 1, 0, 4'h0);
        RtD = 3; WriteRegE = 3;
`ifdef PIPE_BRANCH_FLUSH_EN
        PCSrcD = 1'b1;
`endif
        #1;
        checkOutput("fd_stalled", 16'({StallD, FlushD}), 16'b10);
        tick();
        WriteRegE = 0;
        #1;
        checkOutput("fd_taken", 16'({StallD, FlushD}), 16'({1'b0, BFE}));
`ifdef PIPE_BRANCH_FLUSH_EN
        PCSrcD = 1'b0; JumpD = 1'b1;
        #1;
        checkOutput("fd_jump", 16'(FlushD), 16'h1);
        JumpD = 1'b0;
        #1;
        checkOutput("fd_none", 16'(FlushD), 16'h0);
`endif
        setD(0, 0, 0, 0, 0, 0, 0, 4'h0);
        clearAddr();

        // Randomized phase against the model.
        $display("[TB] random phase");
        RST_N = 1'b0;
        tick();
        tick();
        modelReset();
        for (int n = 0; n < 1500; n++) begin
            applyStimulus();
            #1;
            modelCheck();
            @(posedge CLK);
            modelUpdate();
            @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
